spi_master_param: RTL
=====================

# spi_master_param

Parametrised full-duplex SPI master: the next generation of the board's SPI read path, generalised from a fixed 8-bit, receive-only, mode-3 reader. It supports any data width, all four CPOL/CPHA modes selected at run time, a run-time SCLK divider, MOSI transmit, and an explicit start/busy/done handshake. It sits between board control logic (buttons, UART command decoder) and external SPI slaves (ADC, sensors).

## Interface
- DATA_W, 8: bits per transaction, 2..32.
- DIV_W, 8: width of `clk_div`.
- LSB_FIRST, 0: 1 shifts bit 0 first; 0 shifts the MSB first.
- clk  in  1  system clock.
- n_rst  in  1  reset, asynchronous, active-low.
- start  in  1  request; accepted only in IDLE (`busy`=0). Ignored otherwise.
- mode  in  2  {CPOL,CPHA}; latched at accept.
- clk_div  in  DIV_W  half-period H = `clk_div`+1 clk cycles; latched at accept.
- tx_data  in  DATA_W  transmit word; latched at accept.
- rx_data  out  DATA_W  last received word; reset 0; changes only when `done` is asserted.
- busy  out  1  high from the accept edge until `done`; reset 0.
- done  out  1  one-cycle completion pulse; reset 0.
- sclk  out  1  SPI clock; reset 0.
- cs_n  out  1  chip select, active-low; reset 1.
- mosi  out  1  serial out; reset 0; 0 whenever `cs_n`=1.
- miso  in  1  serial in; treated as synchronous to `sclk`; not resynchronised.

## Operation
- FSM states: IDLE, LEAD, XFER, TRAIL.
- IDLE
  - `cs_n`=1; `sclk` loads the live `mode[1]` each cycle, so the idle level is correct before select.
  - On `start`: latch `mode`, `clk_div` and `tx_data`, clear the edge counter, then go to LEAD.
- LEAD
  - `cs_n`=0; `sclk`=CPOL; `mosi` presents bit 0 of the shift order.
  - Lasts H cycles, then go to XFER.
- XFER
  - `sclk` toggles every H cycles, 2·DATA_W edges in total. Odd edges are leading edges; even edges are trailing edges.
  - CPHA=0: sample `miso` on leading edges 1..DATA_W. Shift `mosi` on trailing edges 1..DATA_W-1.
  - CPHA=1: shift `mosi` on leading edges 2..DATA_W. Sample `miso` on trailing edges 1..DATA_W.
  - After the last edge `sclk` is back at CPOL; go to TRAIL.
- TRAIL
  - `cs_n`=0 for H cycles.
  - On exit, in the same clock cycle: `cs_n`→1, `busy`→0, `done`=1, `rx_data` ← receive shift register. Return to IDLE.
- Receive bit order matches LSB_FIRST, so the first sampled bit lands in rx bit DATA_W-1 (MSB-first) or bit 0 (LSB-first).
- Changes on `mode`, `clk_div` or `tx_data` during a transaction have no effect.
- Reset at any time: return to IDLE immediately with all outputs at reset values. `rx_data` is cleared and no `done` is issued.

## Timing
- Accept edge = the clk edge that samples `start` high in IDLE. `cs_n` falls and `busy` rises at that edge.
- `done` is high in the cycle starting (2·DATA_W+2)·H clk cycles after the accept edge.
- `start` held high through `done` starts a new transaction on the cycle after `done`, since IDLE is reached then. Minimum `cs_n` high time is 1 cycle.
- `clk_div`=0 gives H=1, so `sclk` = clk/2.
- `clk_div`=all-ones gives H=2^DIV_W. The divider counter is DIV_W+1 bits or compares against `clk_div` without overflow.
- The edge counter holds 0..2·DATA_W and has width clog2(2·DATA_W+1).

## Structure
- Shared package `spi_pkg`: state encodings (IDLE/LEAD/XFER/TRAIL) and mode constants (MODE0..MODE3).
- Sub-module `spi_clk_gen`:
  - inputs: enable, latched `clk_div`.
  - outputs: half-period tick, leading/trailing edge strobes.
  - It owns the divider counter and the `sclk` register.
- The top level holds the FSM, the shift registers and `rx_data`.

## Test plan
- Mode 0, DATA_W=8, `clk_div`=1, `tx_data`=0xA5, slave loopback `miso`=`mosi` → `mosi` sequence 1,0,1,0,0,1,0,1 at leading edges; `rx_data`=0xA5; `done` 36 cycles after accept.
- Modes 1/2/3 with a slave model returning 0x3C, `tx_data`=0xC3 → `rx_data`=0x3C; slave captures 0xC3; idle `sclk` = CPOL before `cs_n` falls and after it rises.
- LSB_FIRST=1, DATA_W=12, `tx_data`=0x801, `clk_div`=0 → first `mosi` bit 1, last bit 1; `rx_data`=0x801 via loopback; `done` at 26 cycles.
- `start` pulsed mid-transfer and `tx_data`/`mode` changed mid-transfer → no effect; exactly one `done`; `cs_n` low for exactly 18·H cycles.
- `n_rst` asserted at XFER edge 5 → `cs_n`=1, `sclk`=0, `busy`=0, `rx_data`=0 immediately; no `done`; next `start` completes normally.
- `start` held high continuously → back-to-back transactions, `cs_n` high exactly 1 cycle between them, one `done` per transaction.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI master.
// Holds the controller state encoding and the {CPOL,CPHA} mode constants.
package spi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLead,
        StXfer,
        StTrail
    } spi_state_e;

    // mode = {CPOL, CPHA}
    localparam logic [1:0] Mode0 = 2'b00;
    localparam logic [1:0] Mode1 = 2'b01;
    localparam logic [1:0] Mode2 = 2'b10;
    localparam logic [1:0] Mode3 = 2'b11;

endpackage

// File: rtl/spi_master_param_clk_gen.sv
// SCLK generator for spi_master_param.
// Ports:
//   clk, n_rst       system clock, asynchronous active-low reset
//   en               divider runs while high (any non-idle state)
//   xfer             sclk toggles on each half-period tick while high
//   cpol             level sclk is loaded with when not transferring
//   clk_div          latched divider; half-period H = clk_div + 1 cycles
//   tick             half-period elapsed (this cycle is the last of H)
//   lead_edge        tick that moves sclk away from cpol
//   trail_edge       tick that returns sclk to cpol
//   sclk             registered SPI clock
module spi_clk_gen #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             xfer,
    input  logic             cpol,
    input  logic [DIV_W-1:0] clk_div,
    output logic             tick,
    output logic             lead_edge,
    output logic             trail_edge,
    output logic             sclk
);

    logic [DIV_W-1:0] div_cnt;

    // Counter restarts on the tick, so it never has to exceed clk_div.
    assign tick       = en && (div_cnt == clk_div);
    assign lead_edge  = tick && xfer && (sclk == cpol);
    assign trail_edge = tick && xfer && (sclk != cpol);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else begin
            if (!en || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (xfer) begin
                if (tick) begin
                    sclk <= ~sclk;
                end
            end else begin
                sclk <= cpol;
            end
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master with start/busy/done handshake.
// Ports:
//   clk, n_rst   system clock, asynchronous active-low reset
//   start        transaction request, honoured only when idle
//   mode         {CPOL,CPHA}, latched at accept
//   clk_div      sclk half-period minus one, latched at accept
//   tx_data      word to transmit, latched at accept
//   rx_data      last received word, updated together with done
//   busy         high from accept until done
//   done         one-cycle completion pulse
//   sclk, cs_n   SPI clock and active-low chip select
//   mosi, miso   serial data out / in (miso sampled in the sclk domain)
module spi_master_param
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned LSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned       EDGE_W    = $clog2(2 * DATA_W + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    spi_state_e        state;
    logic [1:0]        mode_l;
    logic [DIV_W-1:0]  div_l;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [EDGE_W-1:0] edge_cnt;

    logic              tick;
    logic              lead_edge;
    logic              trail_edge;
    logic              gen_en;
    logic              gen_xfer;
    logic              cpol;
    logic              sample;
    logic              shift;
    logic              last_edge;
    logic              tx_first;
    logic              tx_rot_first;
    logic [DATA_W-1:0] tx_rot;
    logic [DATA_W-1:0] rx_shifted;

    always_comb begin
        gen_en    = (state != StIdle);
        gen_xfer  = (state == StXfer);
        // Idle sclk follows the live mode so the level is right before select.
        cpol      = (state == StIdle) ? mode[1] : mode_l[1];
        // edge_cnt holds the number of edges already issued; the current tick
        // is edge edge_cnt+1.
        sample    = mode_l[0] ? trail_edge : lead_edge;
        shift     = mode_l[0] ? (lead_edge && (edge_cnt != '0))
                              : (trail_edge && (edge_cnt != LAST_EDGE));
        last_edge = gen_xfer && tick && (edge_cnt == LAST_EDGE);
        if (LSB_FIRST != 0) begin
            tx_first     = tx_data[0];
            tx_rot       = {tx_sr[0], tx_sr[DATA_W-1:1]};
            tx_rot_first = tx_rot[0];
            rx_shifted   = {miso, rx_sr[DATA_W-1:1]};
        end else begin
            tx_first     = tx_data[DATA_W-1];
            tx_rot       = {tx_sr[DATA_W-2:0], tx_sr[DATA_W-1]};
            tx_rot_first = tx_rot[DATA_W-1];
            rx_shifted   = {rx_sr[DATA_W-2:0], miso};
        end
    end

    spi_clk_gen #(
        .DIV_W(DIV_W)
    ) u_clk_gen (
        .clk       (clk),
        .n_rst     (n_rst),
        .en        (gen_en),
        .xfer      (gen_xfer),
        .cpol      (cpol),
        .clk_div   (div_l),
        .tick      (tick),
        .lead_edge (lead_edge),
        .trail_edge(trail_edge),
        .sclk      (sclk)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= StIdle;
            mode_l   <= '0;
            div_l    <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            edge_cnt <= '0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        mode_l   <= mode;
                        div_l    <= clk_div;
                        tx_sr    <= tx_data;
                        mosi     <= tx_first;
                        edge_cnt <= '0;
                        cs_n     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= StLead;
                    end
                end
                StLead: begin
                    if (tick) begin
                        state <= StXfer;
                    end
                end
                StXfer: begin
                    if (tick) begin
                        edge_cnt <= edge_cnt + 1'b1;
                    end
                    if (sample) begin
                        rx_sr <= rx_shifted;
                    end
                    if (shift) begin
                        tx_sr <= tx_rot;
                        mosi  <= tx_rot_first;
                    end
                    if (last_edge) begin
                        state <= StTrail;
                    end
                end
                StTrail: begin
                    if (tick) begin
                        cs_n    <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_sr;
                        mosi    <= 1'b0;
                        state   <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
